// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared digit indices, BCD limits and helpers for clock_adjust_ctrl
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 6;

    // Digit positions inside the 24-bit HH:MM:SS vector (4 bits each, LSB first)
    localparam logic [2:0] DIG_SU = 3'd0;
    localparam logic [2:0] DIG_ST = 3'd1;
    localparam logic [2:0] DIG_MU = 3'd2;
    localparam logic [2:0] DIG_MT = 3'd3;
    localparam logic [2:0] DIG_HU = 3'd4;
    localparam logic [2:0] DIG_HT = 3'd5;

    // Highest legal value of each digit; hour units drop to 3 in the twenties
    localparam bcd_t LIM_SU    = 4'd9;
    localparam bcd_t LIM_ST    = 4'd5;
    localparam bcd_t LIM_MU    = 4'd9;
    localparam bcd_t LIM_MT    = 4'd5;
    localparam bcd_t LIM_HU    = 4'd9;
    localparam bcd_t LIM_HU_20 = 4'd3;
    localparam bcd_t LIM_HT    = 4'd2;

    function automatic bcd_t digit_limit(input logic [2:0] idx, input bcd_t hour_tens);
        bcd_t lim;
        case (idx)
            DIG_SU:  lim = LIM_SU;
            DIG_ST:  lim = LIM_ST;
            DIG_MU:  lim = LIM_MU;
            DIG_MT:  lim = LIM_MT;
            DIG_HU:  lim = (hour_tens == LIM_HT) ? LIM_HU_20 : LIM_HU;
            DIG_HT:  lim = LIM_HT;
            default: lim = 4'd0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - one-second prescaler, terminal-count pulse while enabled
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   i_en    in  1 = count, 0 = hold counter at 0
//   o_pulse out high during the cycle the counter sits at CLK_HZ-1 (combinational)
module sec_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_pulse
);

    localparam int CW = $clog2(CLK_HZ);
    localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_tc;

    assign w_at_tc = (r_cnt == TC);
    assign o_pulse = i_en && w_at_tc;

    // Disabling discards any partial second so the next one is a full CLK_HZ cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || w_at_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/clock_adjust_ctrl.sv
// rtl/clock_adjust_ctrl.sv - HH:MM:SS timekeeper with run mode and per-digit adjust edits
// Ports:
//   CLOCK_50    in  system clock
//   reset       in  asynchronous active-high reset
//   adjust      in  1 = run, 0 = adjust (edits applied)
//   select[3:0] in  digit under edit, 0 = sec units .. 5 = hour tens, 6..15 = none
//   add         in  increment request, rising edge significant
//   clr         in  clear request, level
//   digits      out BCD HH:MM:SS, [3:0] = sec units .. [23:20] = hour tens
//   sec_tick    out one-cycle pulse per run-mode second
//   digit_blank out per-digit blank mask
// Optional feature macro: CLOCK_ADJ_BLINK_EN (2 Hz blink of the digit under edit)
module clock_adjust_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        adjust,
    input  logic [3:0]  select,
    input  logic        add,
    input  logic        clr,
    output logic [23:0] digits,
    output logic        sec_tick,
    output logic [5:0]  digit_blank
);

    bcd_t       r_d [NUM_DIGITS];
    logic       r_add_q;
    logic       r_sec_tick;

    logic       w_tick;
    logic       w_sel_valid;
    logic [2:0] w_sel;
    logic       w_add_edge;
    bcd_t       w_edit_val;
    logic       w_force_hu;
    bcd_t       w_run_next [NUM_DIGITS];

    sec_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_en    (adjust),
        .o_pulse (w_tick)
    );

    assign w_sel       = select[2:0];
    assign w_sel_valid = (select < 4'd6);
    assign w_add_edge  = add && !r_add_q;

    // Single-digit edit: wraps at that digit's own limit, never carries
    assign w_edit_val = (r_d[w_sel] >= digit_limit(w_sel, r_d[DIG_HT])) ? 4'd0
                                                                         : r_d[w_sel] + 4'd1;

    // Hour tens becoming 2 would leave an illegal 24..29 unless hour units are clamped
    assign w_force_hu = (w_sel == DIG_HT) && (w_edit_val == LIM_HT) && (r_d[DIG_HU] > LIM_HU_20);

    // One-second advance with full ripple carry; 23:59:59 rolls to 00:00:00
    // because hour units wrap at 3 and then hour tens wraps at 2.
    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_run_next[i] = r_d[i];
            if (carry) begin
                if (r_d[i] >= digit_limit(3'(i), r_d[DIG_HT])) begin
                    w_run_next[i] = 4'd0;
                end else begin
                    w_run_next[i] = r_d[i] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    // add_q resets high so an add held through reset release does not fire
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_d[i] <= 4'd0;
            end
            r_add_q    <= 1'b1;
            r_sec_tick <= 1'b0;
        end else begin
            r_add_q    <= add;
            r_sec_tick <= w_tick;
            if (adjust) begin
                if (w_tick) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_d[i] <= w_run_next[i];
                    end
                end
            end else if (w_sel_valid) begin
                // clr has priority; a coincident add edge is consumed via add_q
                if (clr) begin
                    r_d[w_sel] <= 4'd0;
                end else if (w_add_edge) begin
                    r_d[w_sel] <= w_edit_val;
                    if (w_force_hu) begin
                        r_d[DIG_HU] <= LIM_HU_20;
                    end
                end
            end
        end
    end

    assign digits   = {r_d[DIG_HT], r_d[DIG_HU], r_d[DIG_MT], r_d[DIG_MU], r_d[DIG_ST], r_d[DIG_SU]};
    assign sec_tick = r_sec_tick;

`ifdef CLOCK_ADJ_BLINK_EN
    localparam int BLINK_TC = CLK_HZ / 4;
    localparam int BW       = $clog2(BLINK_TC) + 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [5:0]    r_digit_blank;
    logic          w_blink_wrap;
    logic          w_phase_next;

    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_TC - 1));
    assign w_phase_next = w_blink_wrap ? ~r_blink_phase : r_blink_phase;

    // Held clear in run mode so the edited digit starts visible on entry to adjust
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_digit_blank <= '0;
        end else if (adjust) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_digit_blank <= '0;
        end else begin
            r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
            r_blink_phase <= w_phase_next;
            r_digit_blank <= w_sel_valid ? (6'(w_phase_next) << w_sel) : 6'd0;
        end
    end

    assign digit_blank = r_digit_blank;
`else
    assign digit_blank = 6'd0;
`endif

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// tb/tb_clock_adjust_ctrl.sv - directed scoreboard bench for clock_adjust_ctrl at CLK_HZ=8
module tb_clock_adjust_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        adjust;
    logic [3:0]  select;
    logic        add;
    logic        clr;
    logic [23:0] digits;
    logic        sec_tick;
    logic [5:0]  digit_blank;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [23:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    clock_adjust_ctrl #(
        .CLK_HZ (8)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .adjust      (adjust),
        .select      (select),
        .add         (add),
        .clr         (clr),
        .digits      (digits),
        .sec_tick    (sec_tick),
        .digit_blank (digit_blank)
    );

    task automatic expect_v(input string tag, input logic [23:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare_v(input logic [23:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        expect_v(tag, exp);
        compare_v(obs);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add_n(input logic [3:0] sel, input int n);
        select = sel;
        repeat (n) begin
            add = 1'b1;
            step(1);
            add = 1'b0;
            step(1);
        end
    endtask

    task automatic clr_d(input logic [3:0] sel);
        select = sel;
        clr    = 1'b1;
        step(1);
        clr    = 1'b0;
    endtask

    logic [5:0] blink_exp [6];

    initial begin
`ifdef CLOCK_ADJ_BLINK_EN
        blink_exp = '{6'h00, 6'h10, 6'h10, 6'h00, 6'h00, 6'h10};
`else
        blink_exp = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
`endif
        reset  = 1'b1;
        adjust = 1'b1;
        select = 4'd15;
        add    = 1'b0;
        clr    = 1'b0;
        step(2);
        chk("reset_digits", digits, 24'h000000);
        chk("reset_tick", 24'(sec_tick), 24'd0);
        chk("reset_blank", 24'(digit_blank), 24'd0);

        // First second from reset release
        reset = 1'b0;
        step(7);
        chk("pre_tick_digits", digits, 24'h000000);
        chk("pre_tick", 24'(sec_tick), 24'd0);
        step(1);
        chk("first_sec_digits", digits, 24'h000001);
        chk("first_sec_tick", 24'(sec_tick), 24'd1);
        step(1);
        chk("tick_one_cycle", 24'(sec_tick), 24'd0);

        // Preload 23:59:59 via edits
        adjust = 1'b0;
        for (int i = 0; i < 6; i++) clr_d(4'(i));
        add_n(4'd5, 2);
        add_n(4'd4, 3);
        add_n(4'd3, 5);
        add_n(4'd2, 9);
        add_n(4'd1, 5);
        add_n(4'd0, 9);
        chk("preload", digits, 24'h235959);
        adjust = 1'b1;
        select = 4'd15;
        step(7);
        chk("preload_hold", digits, 24'h235959);
        step(1);
        chk("midnight_roll", digits, 24'h000000);
        chk("midnight_tick", 24'(sec_tick), 24'd1);
        step(1);
        chk("midnight_tick_end", 24'(sec_tick), 24'd0);

        // Seconds tens wrap without carry into minutes
        adjust = 1'b0;
        add_n(4'd2, 4);
        add_n(4'd1, 5);
        chk("st_at_5", digits, 24'h000450);
        add_n(4'd1, 1);
        chk("st_wrap", digits, 24'h000400);

        // Hour tens to 2 clamps hour units
        add_n(4'd5, 1);
        add_n(4'd4, 9);
        chk("hour_19", digits, 24'h190400);
        add_n(4'd5, 1);
        chk("hour_clamp_23", digits, 24'h230400);
        add_n(4'd5, 1);
        chk("hour_03", digits, 24'h030400);

        // Held add fires once; clr beats a coincident add edge
        select = 4'd2;
        add    = 1'b1;
        step(10);
        add    = 1'b0;
        step(1);
        chk("add_held_once", digits, 24'h030500);
        add = 1'b1;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
        add = 1'b0;
        step(1);
        chk("clr_wins", digits, 24'h030000);

        // No-digit select ignores edits
        add_n(4'd9, 2);
        clr_d(4'd9);
        step(1);
        chk("select_none", digits, 24'h030000);

        // Run mode ignores edits
        adjust = 1'b1;
        select = 4'd0;
        add    = 1'b1;
        clr    = 1'b1;
        step(1);
        add    = 1'b0;
        clr    = 1'b0;
        step(1);
        chk("run_ignores_edits", digits, 24'h030000);
        step(5);
        chk("run_pre_tick", 24'(sec_tick), 24'd0);
        step(1);
        chk("run_tick_digits", digits, 24'h030001);
        chk("run_tick", 24'(sec_tick), 24'd1);

        // Mid-second adjust drop discards partial second
        step(4);
        adjust = 1'b0;
        step(2);
        adjust = 1'b1;
        step(7);
        chk("partial_discard", digits, 24'h030001);
        chk("partial_no_tick", 24'(sec_tick), 24'd0);
        step(1);
        chk("full_sec_after_resume", digits, 24'h030002);
        chk("resume_tick", 24'(sec_tick), 24'd1);

        // Blink mask on hour units
        select = 4'd4;
        adjust = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk("blink_mask", 24'(digit_blank), 24'(blink_exp[k]));
        end
        adjust = 1'b1;
        step(1);
        chk("blink_off_run", 24'(digit_blank), 24'd0);
        chk("blink_digits_kept", digits, 24'h030002);

        // Async reset and add held through reset release
        add   = 1'b1;
        reset = 1'b1;
        #2;
        chk("async_reset", digits, 24'h000000);
        step(1);
        adjust = 1'b0;
        select = 4'd0;
        reset  = 1'b0;
        step(2);
        chk("add_through_reset", digits, 24'h000000);
        add = 1'b0;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
